// File: rtl/multi_spi_cfg_seq_if.sv
// rtl/multi_spi_cfg_seq_if.sv - table, SPI and status signals of the multi-chip SPI config sequencer
interface multi_spi_cfg_seq_if #(
  parameter int N_CH  = 2,
  parameter int DW    = 24,
  parameter int IDX_W = 6
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                   i_start;
  logic                   i_lock;
  logic [CH_W+IDX_W-1:0]  o_tbl_addr;
  logic [DW:0]            i_tbl_data;
  logic                   o_spi_sclk;
  logic                   o_spi_mosi;
  logic [N_CH-1:0]        o_spi_cs_n;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_err;
  logic [CH_W-1:0]        o_chan;

  modport master (
    input  i_start, i_lock, i_tbl_data,
    output o_tbl_addr, o_spi_sclk, o_spi_mosi, o_spi_cs_n, o_busy, o_done, o_err, o_chan
  );

  modport slave (
    output i_start, i_lock, i_tbl_data,
    input  o_tbl_addr, o_spi_sclk, o_spi_mosi, o_spi_cs_n, o_busy, o_done, o_err, o_chan
  );
endinterface

// File: rtl/multi_spi_cfg_seq.sv
// rtl/multi_spi_cfg_seq.sv - table-driven SPI configuration sequencer for N_CH chips with PLL lock wait
// Optional macro CFG_LOCK_RETRY_EN: retry the lock channel up to 3 times before flagging an error.
module multi_spi_cfg_seq #(
  parameter int N_CH    = 2,
  parameter int DW      = 24,
  parameter int IDX_W   = 6,
  parameter int CLK_DIV = 8,
  parameter int LOCK_CH = 0,
  parameter int LOCK_TO = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_spi_cfg_seq_if.master  bus
);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HP_LAST = 2 * DW + 3;
  localparam int HW      = $clog2(HP_LAST + 1);
  localparam int CW      = $clog2(2 * CLK_DIV);

  localparam logic [CW-1:0]    HALF_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    GAP_END    = CW'(2 * CLK_DIV - 1);
  localparam logic [HW-1:0]    HP_ONE     = HW'(1);
  localparam logic [HW-1:0]    HP_TWO     = HW'(2);
  localparam logic [HW-1:0]    HP_BITS    = HW'(2 * DW);
  localparam logic [HW-1:0]    HP_CS_END  = HW'(2 * DW + 1);
  localparam logic [HW-1:0]    HP_END     = HW'(HP_LAST);
  localparam logic [IDX_W-1:0] IDX_MAX    = '1;
  localparam logic [19:0]      TO_END     = 20'(LOCK_TO - 1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
  localparam logic [CH_W-1:0]  LOCK_CH_V  = CH_W'(LOCK_CH);
  localparam bit               LOCK_VALID = (LOCK_CH >= 0) && (LOCK_CH < N_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_GAP, S_LOCKWAIT, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     sreg_q, sreg_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HW-1:0]     hp_q, hp_d;
  logic [3:0]        lk_q, lk_d;
  logic [19:0]       to_q, to_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              next_chan;
  logic              is_lock_ch;
  logic              lock_meta, lock_s;
`ifdef CFG_LOCK_RETRY_EN
  logic [1:0]        retry_q, retry_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.i_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      sreg_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      hp_q    <= '0;
      lk_q    <= '0;
      to_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CFG_LOCK_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      sreg_q  <= sreg_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      lk_q    <= lk_d;
      to_q    <= to_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CFG_LOCK_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign is_lock_ch = LOCK_VALID && (ch_q == LOCK_CH_V);

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    sreg_d    = sreg_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    lk_d      = lk_q;
    to_d      = to_q;
    done_d    = done_q;
    err_d     = err_q;
    next_chan = 1'b0;
`ifdef CFG_LOCK_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_FETCH;
          ch_d    = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef CFG_LOCK_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sreg_d  = bus.i_tbl_data[DW-1:0];
        last_d  = bus.i_tbl_data[DW];
        cnt_d   = '0;
        hp_d    = '0;
        state_d = S_SHIFT;
      end
      // Each half-period: 0 guard, 1 select setup, 2..2DW bit clocks, 2DW+1 deselect hold, rest guard.
      S_SHIFT: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (hp_q == HP_END) state_d = S_GAP;
          else                hp_d    = hp_q + HP_ONE;
          if (!hp_q[0] && hp_q >= HP_TWO) sreg_d = {sreg_q[DW-2:0], 1'b0};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (!last_q && idx_q != IDX_MAX) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
          end else if (is_lock_ch) begin
            lk_d    = '0;
            to_d    = '0;
            state_d = S_LOCKWAIT;
          end else begin
            next_chan = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCKWAIT: begin
        lk_d = lock_s ? lk_q + 4'd1 : 4'd0;
        to_d = to_q + 20'd1;
        if (lock_s && lk_q == 4'd15) begin
          next_chan = 1'b1;
        end else if (to_q == TO_END) begin
`ifdef CFG_LOCK_RETRY_EN
          if (retry_q != 2'd3) begin
            retry_d = retry_q + 2'd1;
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
`else
          err_d   = 1'b1;
          state_d = S_ERR;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (next_chan) begin
      if (ch_q == LAST_CH) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        idx_d   = '0;
        state_d = S_FETCH;
      end
    end
  end

  logic cs_act;
  assign cs_act         = (state_q == S_SHIFT) && (hp_q >= HP_ONE) && (hp_q <= HP_CS_END);
  assign bus.o_spi_cs_n = cs_act ? ~(N_CH'(1) << ch_q) : '1;
  assign bus.o_spi_sclk = (state_q == S_SHIFT) && (hp_q >= HP_TWO) && (hp_q <= HP_BITS) && !hp_q[0];
  assign bus.o_spi_mosi = (state_q == S_SHIFT) && (hp_q >= HP_ONE) && (hp_q <= HP_BITS) && sreg_q[DW-1];
  assign bus.o_tbl_addr = {ch_q, idx_q};
  assign bus.o_busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_chan     = ch_q;
endmodule

// File: tb/tb_multi_spi_cfg_seq.sv
// tb/tb_multi_spi_cfg_seq.sv - randomized self-checking bench for multi_spi_cfg_seq
module tb_multi_spi_cfg_seq;
  localparam int N_CH = 2, DW = 24, IDX_W = 6, CLK_DIV = 2, LOCK_CH = 0, LOCK_TO = 1000;
  localparam int DEPTH = 1 << IDX_W;
  localparam int WORD_CYC = 2 + 2 * CLK_DIV * (DW + 2) + 2 * CLK_DIV;
  localparam int RUN_LIMIT = 20000;
`ifdef CFG_LOCK_RETRY_EN
  localparam int REPS = 4;
`else
  localparam int REPS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_spi_cfg_seq_if #(.N_CH(N_CH), .DW(DW), .IDX_W(IDX_W)) bus ();

  multi_spi_cfg_seq #(
    .N_CH(N_CH), .DW(DW), .IDX_W(IDX_W), .CLK_DIV(CLK_DIV), .LOCK_CH(LOCK_CH), .LOCK_TO(LOCK_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW:0] mem [0:N_CH*DEPTH-1];
  always @(posedge clk) bus.i_tbl_data <= mem[bus.o_tbl_addr];

  typedef struct { int chip; logic [31:0] data; int nbits; int lead; int tail; } frame_t;
  typedef struct { int chip; logic [31:0] data; } exp_t;
  frame_t frames[$];
  exp_t   exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // SPI pin monitor: rebuilds frames from the wires, sampled on the falling clk edge.
  logic        prev_sclk = 1'b0;
  logic        in_frame  = 1'b0;
  int          cur_chip, cur_bits, mon_cyc, t_fall, t_rise1, t_lastfall, viol;
  logic [31:0] cur_data;
  initial begin cur_bits = 0; mon_cyc = 0; viol = 0; end

  always @(negedge clk) begin
    mon_cyc++;
    if (rst) begin
      in_frame  = 1'b0;
      cur_bits  = 0;
      prev_sclk = 1'b0;
    end else begin
      if (bus.o_spi_cs_n != '1 && bus.o_spi_cs_n != ~(N_CH'(1) << bus.o_chan)) viol++;
      if (!in_frame && bus.o_spi_cs_n != '1) begin
        in_frame = 1'b1;
        for (int i = 0; i < N_CH; i++) if (!bus.o_spi_cs_n[i]) cur_chip = i;
        cur_bits = 0;
        cur_data = '0;
        t_fall   = mon_cyc;
      end
      if (in_frame) begin
        if (!prev_sclk && bus.o_spi_sclk) begin
          if (cur_bits == 0) t_rise1 = mon_cyc;
          cur_data = {cur_data[30:0], bus.o_spi_mosi};
          cur_bits++;
        end
        if (prev_sclk && !bus.o_spi_sclk) t_lastfall = mon_cyc;
        if (bus.o_spi_cs_n == '1) begin
          frames.push_back('{cur_chip, cur_data, cur_bits, t_rise1 - t_fall, mon_cyc - t_lastfall});
          in_frame = 1'b0;
        end
      end
      prev_sclk = bus.o_spi_sclk;
    end
  end

  task automatic fill_table(input int n0, input int n1, input bit no_flag);
    logic fl;
    int   n;
    for (int c = 0; c < N_CH; c++) begin
      n = (c == 0) ? n0 : n1;
      for (int i = 0; i < DEPTH; i++) begin
        if (no_flag || i < n - 1) fl = 1'b0;
        else if (i == n - 1)      fl = 1'b1;
        else                      fl = 1'($urandom_range(0, 1));
        mem[c*DEPTH+i] = {fl, DW'($urandom)};
      end
    end
  endtask

  // Reference: walk the table by its flags, independent of any sequencing detail.
  task automatic build_exp(input bit lock_ok, output int exp_cycles);
    int reps, last_ch, nw;
    reps    = lock_ok ? 1 : REPS;
    last_ch = lock_ok ? N_CH - 1 : LOCK_CH;
    nw      = 0;
    exp_q.delete();
    for (int r = 0; r < reps; r++)
      for (int c = 0; c <= last_ch; c++)
        for (int i = 0; i < DEPTH; i++) begin
          exp_q.push_back('{c, 32'(mem[c*DEPTH+i][DW-1:0])});
          nw++;
          if (mem[c*DEPTH+i][DW] || i == DEPTH - 1) break;
        end
    exp_cycles = nw * WORD_CYC + (lock_ok ? 16 : REPS * LOCK_TO);
  endtask

  task automatic do_run(output int cyc, output logic busy0, output logic [1:0] flags0);
    @(negedge clk);
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    busy0  = bus.o_busy;
    flags0 = {bus.o_done, bus.o_err};
    cyc = 0;
    while (bus.o_done !== 1'b1 && bus.o_err !== 1'b1 && cyc < RUN_LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.i_start = 1'b0;
    bus.i_lock  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_assert++; if (bus.o_spi_cs_n !== '1)  begin n_fail++; $display("FAIL reset cs_n: got %b want all 1", bus.o_spi_cs_n); end
    n_assert++; if (bus.o_spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset sclk: got %b want 0", bus.o_spi_sclk); end
    n_assert++; if (bus.o_spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset mosi: got %b want 0", bus.o_spi_mosi); end
    n_assert++; if (bus.o_busy !== 1'b0)     begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.o_busy); end
    n_assert++; if (bus.o_done !== 1'b0)     begin n_fail++; $display("FAIL reset done: got %b want 0", bus.o_done); end
    n_assert++; if (bus.o_err !== 1'b0)      begin n_fail++; $display("FAIL reset err: got %b want 0", bus.o_err); end
    n_assert++; if (bus.o_chan !== '0)       begin n_fail++; $display("FAIL reset chan: got %0d want 0", bus.o_chan); end
    n_assert++; if (bus.o_tbl_addr !== '0)   begin n_fail++; $display("FAIL reset tbl_addr: got %0d want 0", bus.o_tbl_addr); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run(input string name, input int n0, input int n1, input bit no_flag, input bit lock_ok);
    int cyc, exp_cyc;
    logic busy0;
    logic [1:0] flags0;
    fill_table(n0, n1, no_flag);
    if (name == "basic") mem[1] = {1'b0, 24'h5A1234};
    bus.i_lock = lock_ok;
    repeat (4) @(negedge clk);
    build_exp(lock_ok, exp_cyc);
    frames.delete();
    viol = 0;
    do_run(cyc, busy0, flags0);
    n_assert++; if (busy0 !== 1'b1)   begin n_fail++; $display("FAIL %s busy at start: got %b want 1", name, busy0); end
    n_assert++; if (flags0 !== 2'b00) begin n_fail++; $display("FAIL %s flags at start: got %b want 00", name, flags0); end
    n_assert++; if (bus.o_done !== lock_ok)  begin n_fail++; $display("FAIL %s done: got %b want %b", name, bus.o_done, lock_ok); end
    n_assert++; if (bus.o_err !== !lock_ok)  begin n_fail++; $display("FAIL %s err: got %b want %b", name, bus.o_err, !lock_ok); end
    n_assert++; if (bus.o_busy !== 1'b0)     begin n_fail++; $display("FAIL %s busy after: got %b want 0", name, bus.o_busy); end
    n_assert++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s cycles: got %0d want %0d", name, cyc, exp_cyc); end
    n_assert++; if (viol != 0) begin n_fail++; $display("FAIL %s cs_n select: got %0d bad cycles want 0", name, viol); end
    n_assert++; if (frames.size() != exp_q.size()) begin n_fail++; $display("FAIL %s frame count: got %0d want %0d", name, frames.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
      n_assert++;
      if (frames[i].chip != exp_q[i].chip || frames[i].data !== exp_q[i].data || frames[i].nbits != DW ||
          frames[i].lead != CLK_DIV || frames[i].tail != CLK_DIV) begin
        n_fail++;
        $display("FAIL %s frame %0d: got chip %0d data %h bits %0d lead %0d tail %0d want chip %0d data %h bits %0d lead/tail %0d",
                 name, i, frames[i].chip, frames[i].data, frames[i].nbits, frames[i].lead, frames[i].tail,
                 exp_q[i].chip, exp_q[i].data, DW, CLK_DIV);
      end
    end
    if (name == "basic") begin
      n_assert++;
      if (frames.size() < 2 || frames[1].data !== 32'h5A1234) begin
        n_fail++; $display("FAIL basic word 5A1234: got %h want 005a1234", (frames.size() > 1) ? frames[1].data : 32'hx);
      end
    end
  endtask

  task automatic test_flag_hold;
    repeat (20) @(negedge clk);
    n_assert++; if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL err hold: got %b want 1", bus.o_err); end
  endtask

  task automatic test_back_to_back;
    int cyc, exp_cyc;
    logic busy0;
    logic [1:0] flags0;
    fill_table(4, 4, 1'b0);
    bus.i_lock = 1'b1;
    repeat (4) @(negedge clk);
    build_exp(1'b1, exp_cyc);
    frames.delete();
    fork
      do_run(cyc, busy0, flags0);
      begin
        repeat (5) @(negedge clk);
        repeat (3) begin
          repeat ($urandom_range(50, 200)) @(negedge clk);
          bus.i_start = 1'b1;
          @(negedge clk);
          bus.i_start = 1'b0;
        end
      end
    join
    n_assert++; if (flags0 !== 2'b00) begin n_fail++; $display("FAIL b2b flags cleared at start: got %b want 00", flags0); end
    n_assert++; if (cyc != exp_cyc)   begin n_fail++; $display("FAIL b2b cycles: got %0d want %0d", cyc, exp_cyc); end
    n_assert++; if (frames.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b frame count: got %0d want %0d", frames.size(), exp_q.size()); end
    n_assert++; if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b end: got done %b busy %b want 1 0", bus.o_done, bus.o_busy); end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    fill_table(3, 2, 1'b0);
    bus.i_lock = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    n = 0;
    while (!(in_frame && cur_bits == 10) && n < 2000) begin @(posedge clk); #2; n++; end
    n_assert++; if (bus.o_spi_cs_n !== 2'b10) begin n_fail++; $display("FAIL midrst in frame: got cs_n %b want 10", bus.o_spi_cs_n); end
    #1;
    rst = 1'b1;
    #1;
    n_assert++; if (bus.o_spi_cs_n !== '1)  begin n_fail++; $display("FAIL midrst cs_n: got %b want all 1", bus.o_spi_cs_n); end
    n_assert++; if (bus.o_spi_sclk !== 1'b0) begin n_fail++; $display("FAIL midrst sclk: got %b want 0", bus.o_spi_sclk); end
    n_assert++; if (bus.o_busy !== 1'b0)     begin n_fail++; $display("FAIL midrst busy: got %b want 0", bus.o_busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_run("after_rst", 3, 2, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_run("basic", 3, 2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      test_run($sformatf("rand%0d", k), $urandom_range(1, 6), $urandom_range(1, 6), 1'b0, 1'b1);
    test_run("lock_timeout", 3, 2, 1'b0, 1'b0);
    test_flag_hold();
    test_back_to_back();
    test_run("no_flag", 1, 1, 1'b1, 1'b1);
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
